// File: rtl/data_memory_responder.sv
// Main-port data RAM responder: one load/store at a time under busy_main, RISC-V lane select/extend, illegal-access flagging.
// Optional single-cycle fetch read port enabled by DATA_MEMORY_RESPONDER_FETCH_EN.
module data_memory_responder #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] address_main,
    input  logic [2:0]      width_main,
    input  logic            read_request_main,
    input  logic            write_request_main,
    input  logic [XLEN-1:0] write_data_main,
    output logic [XLEN-1:0] data_main,
    output logic            busy_main,
    output logic            error_main,
    input  logic [XLEN-1:0] address_fetch,
    input  logic            fetch_request,
    output logic [XLEN-1:0] data_fetch,
    output logic            fetch_valid
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   idx_q;
    logic [1:0]      off_q;
    logic [2:0]      width_q;
    logic [XLEN-1:0] wdata_q;
    logic            write_q;
    logic            illegal_q;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            accept_c;
    logic            complete_c;
    logic            illegal_c;
    logic [XLEN-1:0] rd_word_c;
    logic [XLEN-1:0] lane_c;
    logic [XLEN-1:0] rd_ext_c;
    logic [XLEN-1:0] wmask_c;
    logic [XLEN-1:0] merged_c;
    logic [4:0]      shift_c;
    logic            mem_we_c;
    logic            busy_d;
    logic [XLEN-1:0] data_d;
    logic            error_d;

    assign accept_c   = (state_q == IDLE) && (read_request_main || write_request_main);
    assign complete_c = (state_q == BUSY) && (cnt_q == '0);

    // Legality is decided at acceptance so only the needed address bits are kept.
    always_comb begin
        illegal_c = 1'b0;
        if (width_main == 3'b011 || width_main == 3'b110 || width_main == 3'b111)
            illegal_c = 1'b1;
        if (write_request_main && width_main[2])
            illegal_c = 1'b1;
        if (width_main[1:0] == 2'b01 && address_main[0])
            illegal_c = 1'b1;
        if (width_main[1:0] == 2'b10 && address_main[1:0] != 2'b00)
            illegal_c = 1'b1;
        if (address_main[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS))
            illegal_c = 1'b1;
        if (read_request_main && write_request_main)
            illegal_c = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction and little-endian byte-enable merge
    always_comb begin
        rd_word_c = mem[idx_q];
        shift_c   = {off_q, 3'b000};
        lane_c    = rd_word_c >> shift_c;
        case (width_q)
            3'b000:  rd_ext_c = {{(XLEN-8){lane_c[7]}}, lane_c[7:0]};
            3'b100:  rd_ext_c = {{(XLEN-8){1'b0}}, lane_c[7:0]};
            3'b001:  rd_ext_c = {{(XLEN-16){lane_c[15]}}, lane_c[15:0]};
            3'b101:  rd_ext_c = {{(XLEN-16){1'b0}}, lane_c[15:0]};
            default: rd_ext_c = rd_word_c;
        endcase
        case (width_q[1:0])
            2'b00:   wmask_c = XLEN'(8'hFF) << shift_c;
            2'b01:   wmask_c = XLEN'(16'hFFFF) << shift_c;
            default: wmask_c = '1;
        endcase
        merged_c = (rd_word_c & ~wmask_c) | ((wdata_q << shift_c) & wmask_c);
    end

    always_comb begin
        busy_d   = (state_d == BUSY);
        data_d   = data_main;
        error_d  = error_main;
        mem_we_c = 1'b0;
        if (complete_c) begin
            error_d = illegal_q;
            if (illegal_q)     data_d   = '0;
            else if (!write_q) data_d   = rd_ext_c;
            else               mem_we_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            width_q    <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            illegal_q  <= 1'b0;
            busy_main  <= 1'b0;
            data_main  <= '0;
            error_main <= 1'b0;
        end else begin
            if (accept_c) begin
                cnt_q     <= CW'(LATENCY - 1);
                idx_q     <= address_main[AW+1:2];
                off_q     <= address_main[1:0];
                width_q   <= width_main;
                wdata_q   <= write_data_main;
                write_q   <= write_request_main;
                illegal_q <= illegal_c;
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            busy_main  <= busy_d;
            data_main  <= data_d;
            error_main <= error_d;
        end
    end

    // RAM contents survive reset; an aborted transaction never reaches its commit edge.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[idx_q] <= merged_c;
    end

`ifdef DATA_MEMORY_RESPONDER_FETCH_EN
    logic fetch_ok_c;
    assign fetch_ok_c = fetch_request && (address_fetch[1:0] == 2'b00) &&
                        (address_fetch[XLEN-1:2] < (XLEN-2)'(DEPTH_WORDS));

    // Same-edge write commit is non-blocking, so the fetch sees the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_fetch  <= '0;
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= fetch_ok_c;
            if (fetch_ok_c) data_fetch <= mem[address_fetch[AW+1:2]];
        end
    end
`else
    logic unused_fetch;
    assign unused_fetch = ^{address_fetch, fetch_request};
    assign data_fetch   = '0;
    assign fetch_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: scoreboard of expected completions, checked with immediate assertions.
module tb_data_memory_responder;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk;
    logic        reset;
    logic [31:0] address_main;
    logic [2:0]  width_main;
    logic        read_request_main;
    logic        write_request_main;
    logic [31:0] write_data_main;
    logic [31:0] data_main;
    logic        busy_main;
    logic        error_main;
    logic [31:0] address_fetch;
    logic        fetch_request;
    logic [31:0] data_fetch;
    logic        fetch_valid;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    data_memory_responder dut (
        .clk                (clk),
        .reset              (reset),
        .address_main       (address_main),
        .width_main         (width_main),
        .read_request_main  (read_request_main),
        .write_request_main (write_request_main),
        .write_data_main    (write_data_main),
        .data_main          (data_main),
        .busy_main          (busy_main),
        .error_main         (error_main),
        .address_fetch      (address_fetch),
        .fetch_request      (fetch_request),
        .data_fetch         (data_fetch),
        .fetch_valid        (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_result(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    // Drive a request for one edge; afterwards scramble the operands to show they were captured.
    task automatic start(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [2:0] w, input logic [31:0] wd, input bit hold);
        @(negedge clk);
        read_request_main  = rd;
        write_request_main = wr;
        address_main       = addr;
        width_main         = w;
        write_data_main    = wd;
        @(posedge clk); #1;
        if (!hold) begin
            read_request_main  = 1'b0;
            write_request_main = 1'b0;
            address_main       = $urandom;
            width_main         = 3'($urandom);
            write_data_main    = $urandom;
        end
    endtask

    // Wait (bounded) for completion, then pop the scoreboard and compare.
    task automatic finish_txn(input string tag, input bit chk_len);
        int   n = 0;
        exp_t e;
        while (busy_main === 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        if (chk_len) check({tag, "_busy_cycles"}, 32'(n), 32'd2);
        else         check({tag, "_busy_done"}, 32'(busy_main), 32'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_data"}, data_main, e.data);
            check({tag, "_error"}, 32'(error_main), 32'(e.err));
        end
    endtask

    task automatic txn(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [2:0] w, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
        expect_result(exp_d, exp_e);
        start(rd, wr, addr, w, wd, 1'b0);
        finish_txn(tag, 1'b1);
    endtask

    initial begin
        reset              = 1'b1;
        address_main       = '0;
        width_main         = '0;
        read_request_main  = 1'b0;
        write_request_main = 1'b0;
        write_data_main    = '0;
        address_fetch      = '0;
        fetch_request      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_main), 32'd0);
        check("rst_data", data_main, 32'd0);
        check("rst_error", 32'(error_main), 32'd0);
        check("rst_data_fetch", data_fetch, 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        txn("sw_10",  1'b0, 1'b1, 32'h10, W, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("lw_10",  1'b1, 1'b0, 32'h10, W, 32'h0, 32'hDEADBEEF, 1'b0);
        txn("sb_13",  1'b0, 1'b1, 32'h13, B, 32'h80, 32'hDEADBEEF, 1'b0);
        txn("lb_13",  1'b1, 1'b0, 32'h13, B, 32'h0, 32'hFFFFFF80, 1'b0);
        txn("lbu_13", 1'b1, 1'b0, 32'h13, BU, 32'h0, 32'h00000080, 1'b0);
        txn("lh_12",  1'b1, 1'b0, 32'h12, H, 32'h0, 32'hFFFF80AD, 1'b0);
        txn("lhu_12", 1'b1, 1'b0, 32'h12, HU, 32'h0, 32'h000080AD, 1'b0);
        txn("lw_10b", 1'b1, 1'b0, 32'h10, W, 32'h0, 32'h80ADBEEF, 1'b0);

        txn("lh_11_misalign", 1'b1, 1'b0, 32'h11, H, 32'h0, 32'h0, 1'b1);
        txn("sw_1000_range",  1'b0, 1'b1, 32'h1000, W, 32'h55, 32'h0, 1'b1);
        txn("both_req_10",    1'b1, 1'b1, 32'h10, W, 32'h11, 32'h0, 1'b1);
        txn("lw_12_misalign", 1'b1, 1'b0, 32'h12, W, 32'h0, 32'h0, 1'b1);
        txn("code_011",       1'b1, 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
        txn("write_bu",       1'b0, 1'b1, 32'h10, BU, 32'hFF, 32'h0, 1'b1);
        txn("lw_10_intact",   1'b1, 1'b0, 32'h10, W, 32'h0, 32'h80ADBEEF, 1'b0);

        txn("sb_fff", 1'b0, 1'b1, 32'hFFF, B, 32'h7F, 32'h80ADBEEF, 1'b0);
        txn("lb_fff", 1'b1, 1'b0, 32'hFFF, B, 32'h0, 32'h0000007F, 1'b0);

        // Reset one cycle into a store must abort it
        txn("sw_20_zero", 1'b0, 1'b1, 32'h20, W, 32'h0, 32'h0000007F, 1'b0);
        start(1'b0, 1'b1, 32'h20, W, 32'h12345678, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy_main), 32'd0);
        check("abort_data", data_main, 32'd0);
        check("abort_error", 32'(error_main), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        txn("lw_20_after_abort", 1'b1, 1'b0, 32'h20, W, 32'h0, 32'h0, 1'b0);

        // Request held through completion re-arms on the following edge
        expect_result(32'h80ADBEEF, 1'b0);
        start(1'b1, 1'b0, 32'h10, W, 32'h0, 1'b1);
        finish_txn("held_first", 1'b1);
        @(posedge clk); #1;
        check("held_rearm_busy", 32'(busy_main), 32'd1);
        read_request_main = 1'b0;
        expect_result(32'h80ADBEEF, 1'b0);
        finish_txn("held_second", 1'b1);

`ifdef DATA_MEMORY_RESPONDER_FETCH_EN
        expect_result(32'h80ADBEEF, 1'b0);
        start(1'b1, 1'b0, 32'h10, W, 32'h0, 1'b0);
        @(negedge clk);
        fetch_request = 1'b1;
        address_fetch = 32'h10;
        @(posedge clk); #1;
        check("fetch_10_data", data_fetch, 32'h80ADBEEF);
        check("fetch_10_valid", 32'(fetch_valid), 32'd1);
        @(negedge clk);
        address_fetch = 32'h12;
        @(posedge clk); #1;
        check("fetch_12_valid", 32'(fetch_valid), 32'd0);
        check("fetch_12_held", data_fetch, 32'h80ADBEEF);
        finish_txn("lw_during_fetch", 1'b0);
        @(negedge clk);
        fetch_request = 1'b0;
        @(posedge clk); #1;
        check("fetch_idle_valid", 32'(fetch_valid), 32'd0);
`else
        @(negedge clk);
        fetch_request = 1'b1;
        address_fetch = 32'h10;
        @(posedge clk); #1;
        check("nofetch_data", data_fetch, 32'd0);
        check("nofetch_valid", 32'(fetch_valid), 32'd0);
        @(negedge clk);
        fetch_request = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
